// File: rtl/uart_os_rx_pkg.sv
// Shared types, constants and divisor table for the oversampling UART receiver.
// baud_to_div maps a baud select to clocks per 1/16 bit; unknown values map to 9600.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  SAMPLE_PT  = 4'd7;

  function automatic logic [15:0] div_of(
    input int unsigned clk_hz,
    input int unsigned rate
  );
    int unsigned q;
    q = (clk_hz + rate * (OVERSAMPLE / 2))
      / (rate * OVERSAMPLE);
    return q[15:0];
  endfunction

  function automatic logic [15:0] baud_to_div(
    input logic [16:0] baud,
    input int unsigned clk_hz
  );
    logic [15:0] d;
    case (baud)
      17'd4800:   d = div_of(clk_hz, 4800);
      17'd9600:   d = div_of(clk_hz, 9600);
      17'd14400:  d = div_of(clk_hz, 14400);
      17'd19200:  d = div_of(clk_hz, 19200);
      17'd38400:  d = div_of(clk_hz, 38400);
      17'd57600:  d = div_of(clk_hz, 57600);
      17'd115200: d = div_of(clk_hz, 115200);
      17'd128000: d = div_of(clk_hz, 128000);
      default:    d = div_of(clk_hz, 9600);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_os_rx_if.sv
// Receive-side holding register handshake: data, error flags, valid/ready.
// master = receiver (drives data/flags/valid), slave = consumer (drives ready).
interface uart_os_rx_if;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data, rx_parity_err,
    output rx_frame_err, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err,
    input  rx_frame_err, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_os_rx_baud_tick.sv
// 16x oversampling tick generator: tick once every div clocks.
// Ports: clk, rst_n, restart (sync, zeroes phase), div, tick.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;
  logic        wrap;

  assign wrap = (cnt == div - 16'd1);
  assign tick = wrap && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_os_rx.sv
// Oversampling UART receiver: rx, rx_en, framing config in; host handshake out
// plus rx_done/overrun_err pulses and busy. Macro UART_RX_MAJORITY_EN: 2-of-3 vote.
module uart_os_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  input  logic          rx_en,
  input  logic [16:0]   baud,
  input  logic [3:0]    length,
  input  logic          parity_en,
  input  logic          parity_type,
  input  logic          stop2,
  output logic          rx_done,
  output logic          overrun_err,
  output logic          busy,
  uart_os_rx_if.master  host
);

  localparam int unsigned SS =
    (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SS-1:0] sync;
  logic          rxs, rxs_d, fall;
  logic          smp, tick, start_ok;
  logic          at_dec, at_end, fin;
  logic          pop, exp_par, fe_fin;
  logic [2:0]    cfg_last;

  state_t        state;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_cnt, last_l;
  logic          pen_l, ptype_l, stop2_l;
  logic [15:0]   div_l;
  logic [7:0]    sh;
  logic          perr, ferr;
  logic [7:0]    data_r;
  logic          pe_r, fe_r, valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      rxs_d <= 1'b1;
    end else begin
      sync  <= {sync[SS-2:0], rx};
      rxs_d <= rxs;
    end
  end

  assign rxs      = sync[SS-1];
  // Break recovery falls out of this: a line stuck low never shows an edge.
  assign fall     = rxs_d && !rxs;
  assign start_ok = (state == IDLE) && rx_en && fall;

  uart_baud_tick u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_ok),
    .div     (div_l),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DEC_PT = SAMPLE_PT + 4'd1;
  logic s6, s7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s6 <= 1'b1;
      s7 <= 1'b1;
    end else if (tick) begin
      if (os_cnt == SAMPLE_PT - 4'd1) s6 <= rxs;
      if (os_cnt == SAMPLE_PT)        s7 <= rxs;
    end
  end

  assign smp = (s6 & s7) | (s6 & rxs) | (s7 & rxs);
`else
  localparam logic [3:0] DEC_PT = SAMPLE_PT;
  assign smp = rxs;
`endif

  assign at_dec = tick && (os_cnt == DEC_PT);
  assign at_end = tick && (os_cnt == 4'd15);
  assign fin    = at_dec &&
                  ((state == STOP1 && !stop2_l) ||
                   (state == STOP2));
  assign fe_fin = ferr | ~smp;
  assign pop    = valid_r && host.rx_ready;
  assign exp_par = ptype_l ? ^sh : ~^sh;

  assign cfg_last =
    (length >= 4'd5 && length <= 4'd8) ?
    3'(length - 4'd1) : 3'd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      last_l      <= 3'd7;
      pen_l       <= 1'b0;
      ptype_l     <= 1'b0;
      stop2_l     <= 1'b0;
      div_l       <= '0;
      sh          <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      data_r      <= '0;
      pe_r        <= 1'b0;
      fe_r        <= 1'b0;
      valid_r     <= 1'b0;
      rx_done     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_done     <= 1'b0;
      overrun_err <= 1'b0;
      if (pop) valid_r <= 1'b0;
      if (state != IDLE && tick)
        os_cnt <= os_cnt + 4'd1;

      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= START;
            os_cnt  <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            last_l  <= cfg_last;
            pen_l   <= parity_en;
            ptype_l <= parity_type;
            stop2_l <= stop2;
            div_l   <= baud_to_div(baud, CLK_FREQ_HZ);
          end
        end
        START: begin
          if (at_dec && smp) state <= IDLE;
          else if (at_end)   state <= DATA;
        end
        DATA: begin
          if (at_dec) sh[bit_cnt] <= smp;
          if (at_end) begin
            if (bit_cnt == last_l)
              state <= pen_l ? PARITY : STOP1;
            else
              bit_cnt <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          if (at_dec && smp != exp_par) perr <= 1'b1;
          if (at_end) state <= STOP1;
        end
        STOP1: begin
          if (at_dec) begin
            if (!smp) ferr <= 1'b1;
            if (!stop2_l) state <= IDLE;
          end else if (at_end && stop2_l) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (at_dec) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Finishing at the stop-bit centre leaves half a bit to catch
      // the next start edge with no idle gap.
      if (fin) begin
        rx_done <= 1'b1;
        if (!valid_r || pop) begin
          data_r  <= sh;
          pe_r    <= perr;
          fe_r    <= fe_fin;
          valid_r <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

  assign busy               = (state != IDLE);
  assign host.rx_data       = data_r;
  assign host.rx_parity_err = pe_r;
  assign host.rx_frame_err  = fe_r;
  assign host.rx_valid      = valid_r;

endmodule

// File: tb/tb_uart_os_rx.sv
// Directed bench for uart_os_rx at a 10 MHz nominal clock.
// Table of framed vectors plus sequences for latency, glitch, overrun, break, reset.
module tb_uart_os_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        rx_en;
  logic [16:0] baud;
  logic [3:0]  length;
  logic        parity_en, parity_type, stop2;
  logic        rx_done, overrun_err, busy;

  uart_os_rx_if bus ();

  uart_os_rx #(
    .CLK_FREQ_HZ (10_000_000),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_en       (rx_en),
    .baud        (baud),
    .length      (length),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .stop2       (stop2),
    .rx_done     (rx_done),
    .overrun_err (overrun_err),
    .busy        (busy),
    .host        (bus)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_HI = 769;
`else
  localparam int LAT_HI = 764;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (rx_done) done_cnt++;
    if (overrun_err) ovr_cnt++;
    if (bus.rx_valid && bus.rx_ready)
      got.push_back(bus.rx_data);
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: no finish after 150000 cycles");
    $fatal(1);
  end

  typedef struct {
    logic [16:0] baud;
    int          div;
    logic [3:0]  len;
    int          nb;
    bit          pen, ptype, pbit;
    bit          s1, s2en, s2;
    logic [7:0]  d;
    logic [7:0]  ed;
    bit          epe, efe;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [16:0] b, input logic [3:0] l,
                     input bit pe, input bit pt, input bit s2);
    baud = b; length = l;
    parity_en = pe; parity_type = pt; stop2 = s2;
  endtask

  task automatic bit_out(input logic b, input int div);
    rx = b;
    repeat (16 * div) @(negedge clk);
  endtask

  task automatic send(input int div, input logic [7:0] d,
                      input int nb, input bit pen, input bit pbit,
                      input bit s1, input bit s2en, input bit s2);
    bit_out(1'b0, div);
    for (int k = 0; k < nb; k++) bit_out(d[k], div);
    if (pen) bit_out(pbit, div);
    bit_out(s1, div);
    if (s2en) bit_out(s2, div);
    rx = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk) bus.rx_ready = 1'b1;
    @(negedge clk) bus.rx_ready = 1'b0;
  endtask

  int d0, o0, lat;

  initial begin
    //        baud    div len nb pe pt pb s1 2e s2 d      ed     pe fe
    v[0]  = '{115200, 5, 8, 8, 0, 0, 0, 1, 0, 0, 8'hA5, 8'hA5, 0, 0};
    v[1]  = '{9600,  65, 5, 5, 1, 1, 1, 1, 0, 0, 8'h13, 8'h13, 0, 0};
    v[2]  = '{9600,  65, 5, 5, 1, 1, 0, 1, 0, 0, 8'h13, 8'h13, 1, 0};
    v[3]  = '{57600, 11, 8, 8, 0, 0, 0, 1, 1, 0, 8'h5A, 8'h5A, 0, 1};
    v[4]  = '{57600, 11, 8, 8, 0, 0, 0, 1, 1, 1, 8'h3C, 8'h3C, 0, 0};
    v[5]  = '{115200, 5, 3, 8, 0, 0, 0, 1, 0, 0, 8'hC3, 8'hC3, 0, 0};
    v[6]  = '{128000, 5, 7, 7, 1, 0, 1, 1, 0, 0, 8'h55, 8'h55, 0, 0};
    v[7]  = '{38400, 16, 6, 6, 0, 0, 0, 0, 0, 0, 8'h2A, 8'h2A, 0, 1};
    v[8]  = '{12345, 65, 8, 8, 0, 0, 0, 1, 0, 0, 8'h81, 8'h81, 0, 0};
    v[9]  = '{19200, 33, 8, 8, 1, 0, 0, 1, 0, 0, 8'h0F, 8'h0F, 1, 0};
    v[10] = '{115200, 5, 15, 8, 1, 1, 1, 1, 0, 0, 8'hFE, 8'hFE, 0, 0};

    rst_n = 1'b0; rx = 1'b1; rx_en = 1'b1;
    bus.rx_ready = 1'b0;
    cfg(17'd115200, 4'd8, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("rst valid", bus.rx_valid, 0);
    chk("rst data", bus.rx_data, 0);
    chk("rst pe", bus.rx_parity_err, 0);
    chk("rst fe", bus.rx_frame_err, 0);
    chk("rst done", rx_done, 0);
    chk("rst ovr", overrun_err, 0);
    chk("rst busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // start-edge to rx_valid latency, 115200 8N1
    lat = 0;
    fork
      send(5, 8'hA5, 8, 0, 0, 1, 0, 0);
      begin
        while (!bus.rx_valid && lat < 2000) begin
          @(posedge clk); #1; lat++;
        end
      end
    join
    checks++;
    if (lat < 760 || lat > LAT_HI) begin
      errors++;
      $display("FAIL latency: got %0d want 760..%0d", lat, LAT_HI);
    end
    repeat (80) @(negedge clk);
    chk("lat data", bus.rx_data, 8'hA5);
    pop();
    chk("lat popped", bus.rx_valid, 0);

    for (int i = 0; i < 11; i++) begin
      cfg(v[i].baud, v[i].len, v[i].pen, v[i].ptype, v[i].s2en);
      d0 = done_cnt;
      send(v[i].div, v[i].d, v[i].nb, v[i].pen, v[i].pbit,
           v[i].s1, v[i].s2en, v[i].s2);
      bit_out(1'b1, v[i].div);
      chk($sformatf("v%0d valid", i), bus.rx_valid, 1);
      chk($sformatf("v%0d data", i), bus.rx_data, v[i].ed);
      chk($sformatf("v%0d pe", i), bus.rx_parity_err, v[i].epe);
      chk($sformatf("v%0d fe", i), bus.rx_frame_err, v[i].efe);
      chk($sformatf("v%0d done", i), done_cnt - d0, 1);
      pop();
      chk($sformatf("v%0d popped", i), bus.rx_valid, 0);
    end

    // short low glitch is a false start
    cfg(17'd115200, 4'd8, 0, 0, 0);
    d0 = done_cnt;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch busy", busy, 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (160) @(negedge clk);
    chk("glitch idle", busy, 0);
    chk("glitch done", done_cnt - d0, 0);
    send(5, 8'h7E, 8, 0, 0, 1, 0, 0);
    bit_out(1'b1, 5);
    chk("after glitch data", bus.rx_data, 8'h7E);
    chk("after glitch valid", bus.rx_valid, 1);
    pop();

    // rx_en low blocks new starts
    rx_en = 1'b0;
    d0 = done_cnt;
    send(5, 8'h42, 8, 0, 0, 1, 0, 0);
    bit_out(1'b1, 5);
    chk("rx_en off done", done_cnt - d0, 0);
    chk("rx_en off valid", bus.rx_valid, 0);
    rx_en = 1'b1;

    // back-to-back with consumer stalled
    d0 = done_cnt; o0 = ovr_cnt;
    send(5, 8'h11, 8, 0, 0, 1, 0, 0);
    send(5, 8'h22, 8, 0, 0, 1, 0, 0);
    bit_out(1'b1, 5);
    chk("ovr data", bus.rx_data, 8'h11);
    chk("ovr done", done_cnt - d0, 2);
    chk("ovr pulses", ovr_cnt - o0, 1);
    pop();
    chk("ovr popped", bus.rx_valid, 0);

    // back-to-back with consumer always ready
    got.delete();
    o0 = ovr_cnt;
    bus.rx_ready = 1'b1;
    send(5, 8'h11, 8, 0, 0, 1, 0, 0);
    send(5, 8'h22, 8, 0, 0, 1, 0, 0);
    bit_out(1'b1, 5);
    bus.rx_ready = 1'b0;
    chk("stream count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("stream first", got[0], 8'h11);
      chk("stream second", got[1], 8'h22);
    end
    chk("stream ovr", ovr_cnt - o0, 0);

    // break: one frame with frame error, then no re-arm while low
    d0 = done_cnt;
    rx = 1'b0;
    repeat (25 * 80) @(negedge clk);
    chk("break done", done_cnt - d0, 1);
    chk("break busy", busy, 0);
    chk("break data", bus.rx_data, 0);
    chk("break fe", bus.rx_frame_err, 1);
    rx = 1'b1;
    repeat (80) @(negedge clk);
    chk("break recover", done_cnt - d0, 1);
    pop();

    // reset mid-DATA clears everything, then reception resumes
    send(5, 8'h99, 8, 0, 0, 1, 0, 0);
    bit_out(1'b1, 5);
    cfg(17'd19200, 4'd8, 0, 0, 0);
    bit_out(1'b0, 33);
    bit_out(1'b1, 33);
    bit_out(1'b0, 33);
    bit_out(1'b1, 33);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst valid", bus.rx_valid, 0);
    chk("midrst data", bus.rx_data, 0);
    chk("midrst done", rx_done, 0);
    @(negedge clk) rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(33, 8'h55, 8, 0, 0, 1, 0, 0);
    bit_out(1'b1, 33);
    chk("post rst valid", bus.rx_valid, 1);
    chk("post rst data", bus.rx_data, 8'h55);
    chk("post rst fe", bus.rx_frame_err, 0);
    pop();

`ifdef UART_RX_MAJORITY_EN
    // one-tick high glitch over the bit-0 centre sample
    cfg(17'd115200, 4'd8, 0, 0, 0);
    bit_out(1'b0, 5);
    rx = 1'b0;
    repeat (38) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rx = 1'b0;
    repeat (37) @(negedge clk);
    for (int k = 1; k < 8; k++) bit_out(1'b0, 5);
    bit_out(1'b1, 5);
    bit_out(1'b1, 5);
    chk("maj valid", bus.rx_valid, 1);
    chk("maj data", bus.rx_data, 8'h00);
    chk("maj fe", bus.rx_frame_err, 0);
    pop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_os_rx.md
Name: uart_os_rx

Overview:
- Single-clock UART receiver using a 16x oversampling tick derived from the system clock. Replaces the divided rx_clk scheme.
- Same framing controls as the existing transmitter: length 5-8, optional parity with parity_type, 1 or 2 stop bits.
- Decodes the serial line into bytes and presents them on a ready/valid output with per-byte error flags.
- Sits between the pad-side serial input and the host/FIFO side of the UART subsystem.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency used to build the divisor table.
- SYNC_STAGES, 2, number of flops in the rx input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, idles high, asynchronous to clk
- rx_en  input  1  enables acceptance of new start bits
- baud  input  17  baud select: 4800/9600/14400/19200/38400/57600/115200/128000; any other value selects 9600
- length  input  4  data bits 5..8; any other value is treated as 8
- parity_en  input  1  a parity bit follows the data bits
- parity_type  input  1  1: expected parity = XOR of data bits; 0: expected parity = XNOR of data bits (matches uart_tx)
- stop2  input  1  two stop bits
- rx_data  output  8  received data, right-aligned, upper unused bits 0
- rx_parity_err  output  1  qualifies rx_data
- rx_frame_err  output  1  qualifies rx_data
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts on rx_valid && rx_ready
- rx_done  output  1  one-cycle pulse when a frame completes
- overrun_err  output  1  one-cycle pulse when a frame is dropped
- busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert via clk): all outputs 0, state IDLE, synchronizer flops preset to 1.
- Sync: rx passes through SYNC_STAGES flops; all decisions use the synchronized value rxs.
- Tick: uart_baud_tick asserts tick once every DIV clocks, where DIV = round(CLK_FREQ_HZ / (16 * baud)).
  - Defaults: 1302, 651, 434, 326, 163, 109, 54, 49.
  - The tick counter restarts at 0 on start-edge detection so bit phase aligns to the edge.
- Latching: baud, length, parity_en, parity_type and stop2 are captured at start detection. Changes mid-frame take effect on the next frame.
- State machine (tick counter os_cnt 0..15, bit counter bit_cnt):
  - IDLE: rx_en && falling edge of rxs -> START; os_cnt=0.
  - START: at os_cnt==7, sample; if 1 -> IDLE (false start, no pulses). At os_cnt==15 -> DATA.
  - DATA: at os_cnt==7, shift sample in, LSB first. At os_cnt==15 with bit_cnt==length-1 -> PARITY if parity_en, else STOP1.
  - PARITY: at os_cnt==7, compare the sample with expected parity; mismatch sets parity_err_r. At os_cnt==15 -> STOP1.
  - STOP1: at os_cnt==7, a sample of 0 sets frame_err_r. If stop2 -> STOP2 at os_cnt==15; else complete the frame at os_cnt==7 and -> IDLE.
  - STOP2: at os_cnt==7, a sample of 0 sets frame_err_r; complete the frame and -> IDLE.
  - Completing at stop-bit centre allows back-to-back frames with no idle gap.
- Completion: rx_done pulses for one cycle.
  - If the holding register is empty, or being popped in the same cycle: load rx_data and both error flags, and set rx_valid.
  - Otherwise: keep the old data, pulse overrun_err, drop the new frame.
- Handshake: rx_valid stays high until rx_valid && rx_ready. rx_data and flags are stable while rx_valid is high.
- rx_en deasserted mid-frame: the current frame still completes; only new starts are blocked.
- rst_n asserted mid-frame: the frame is abandoned immediately, holding register cleared.
- Break (line held low): frame_err=1, rx_data=0. The receiver stays in IDLE until rxs returns high before re-arming edge detection.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (START, DATA, PARITY, STOP) uses a 2-of-3 majority of rxs at os_cnt 6, 7 and 8, and the decision is taken at os_cnt==8.
- Undefined: single sample at os_cnt==7.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - OVERSAMPLE=16, SAMPLE_PT=7
  - function baud_to_div(baud, clk_hz) with the default-to-9600 rule
- Sub-module uart_baud_tick: divisor counter with a sync restart input and a tick output.

Test Plan:
- 115200, 8N1, send 0xA5 -> rx_data=0xA5, both error flags 0, rx_valid rises about 9.5 bit times (8208 clk ±3) after the start edge; pop with rx_ready.
- 9600, length=5, parity_en=1, parity_type=1, send 0x13 with a correct parity bit -> rx_data=0x13, rx_parity_err=0; repeat with the parity bit inverted -> rx_parity_err=1.
- 57600, stop2=1, second stop bit driven 0 -> rx_frame_err=1; next frame 0x3C -> no errors.
- 1-bit-time-long... rather: low glitch of 4 ticks on an idle line -> no rx_done, busy returns to 0; then a valid 0x7E -> received.
- Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun_err pulses once; with rx_ready=1 both are received in order.
- Reset asserted mid-DATA at 19200 -> outputs 0 immediately; the following 0x55 is received correctly. With UART_RX_MAJORITY_EN, a 1-tick glitch at a data-bit centre is rejected.
